sisc_fetch_unit: RTL

//  Instruction-fetch stage of the SISC computer, directly upstream of the control FSM. Holds PC and IR.

---
 rtl/sisc_pkg.sv | 41 ++++
 rtl/sisc_pc_next.sv | 26 ++
 rtl/sisc_fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC core: opcodes, instruction field layout,
// default widths and reset PC, and the fetch FSM state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package sisc_pkg;

  // Default widths and reset vector
  localparam int INSTR_W_DEF  = 32;
  localparam int PC_W_DEF     = 16;
  localparam int RESET_PC_DEF = 0;

  // Instruction field positions; every field except imm is 4 bits wide
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 28;
  localparam int MM_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  // Opcodes
  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_LOD  = 4'h1;
  localparam logic [3:0] OP_STR  = 4'h2;
  localparam logic [3:0] OP_VLD  = 4'h3;
  localparam logic [3:0] OP_VST  = 4'h4;
  localparam logic [3:0] OP_VADD = 4'h5;
  localparam logic [3:0] OP_BRA  = 4'h6;
  localparam logic [3:0] OP_BRR  = 4'h7;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Addressing mode: immediate operand
  localparam logic [3:0] AM_IMM = 4'h8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC computation: PC+1, absolute target, or PC-relative target.
// Latency: combinational. Backpressure: none.
// Ports: pc, imm (from IR), pc_sel (0:+1, 1:branch), br_sel (1:abs, 0:rel) -> pc_next.
module sisc_pc_next #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            pc_sel,
  input  logic            br_sel,
  output logic [PC_W-1:0] pc_next
);

  // All sums wrap modulo 2^PC_W; the relative offset is sign-extended
  // (or truncated) to PC_W so negative offsets wrap backwards naturally.
  always_comb begin
    if (!pc_sel) begin
      pc_next = pc + PC_W'(1);
    end else if (br_sel) begin
      pc_next = PC_W'(imm);
    end else begin
      pc_next = pc + PC_W'(signed'(imm));
    end
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// Instruction fetch stage: holds PC/IR, fetches mem[PC] over req/ack, applies FSM PC updates.
// Latency: zero-wait when im_ack arrives with im_req; otherwise 1 cycle + memory wait.
// Backpressure: fetch_stall is high while a fetch is outstanding; the control FSM must hold.
// Ports: clk/rst_f; FSM controls pc_rst, pc_write, pc_sel, br_sel, ir_load; memory side
//   im_addr/im_req/im_rdata/im_ack; status fetch_stall/halted; pc, ir and the IR field slices.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  output logic [PC_W-1:0]    im_addr,
  output logic               im_req,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               im_ack,
  output logic               fetch_stall,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_calc, fetch_pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic                halted_q;
  logic                ld_ir, ld_fetch_pc, pc_en, clr_halt;

  sisc_pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc      (pc_q),
    .imm     (ir_q[IMM_LSB +: IMM_W]),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .pc_next (pc_calc)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    im_req      = 1'b0;
    im_addr     = pc_q;
    fetch_stall = 1'b0;
    ld_ir       = 1'b0;
    ld_fetch_pc = 1'b0;
    pc_en       = 1'b0;
    pc_d        = pc_calc;
    clr_halt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_f so the request is never visible while in reset.
        im_req = ir_load & ~halted_q & rst_f;
        if (pc_rst) begin
          pc_en    = 1'b1;
          pc_d     = RST_PC;
          clr_halt = 1'b1;
        end else if (im_req && im_ack) begin
          // Zero-wait fetch: only the FSM's sequential increment rides along.
          ld_ir = 1'b1;
          pc_en = pc_write & ~pc_sel;
        end else if (im_req) begin
          // Slow memory: the increment is deferred to ack completion, so
          // pc_write is deliberately dropped here to avoid a double step.
          ld_fetch_pc = 1'b1;
          state_d     = ST_WAIT;
        end else if (pc_write) begin
          pc_en = 1'b1;
        end
      end
      ST_WAIT: begin
        im_req      = 1'b1;
        im_addr     = fetch_pc_q;
        fetch_stall = 1'b1;
        if (pc_rst) begin
          pc_en    = 1'b1;
          pc_d     = RST_PC;
          clr_halt = 1'b1;
          state_d  = ST_IDLE;
        end else if (im_ack) begin
          ld_ir   = 1'b1;
          pc_en   = 1'b1;
          pc_d    = fetch_pc_q + PC_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q       <= RST_PC;
      fetch_pc_q <= RST_PC;
      ir_q       <= '0;
      halted_q   <= 1'b0;
    end else begin
      if (pc_en)       pc_q       <= pc_d;
      if (ld_fetch_pc) fetch_pc_q <= pc_q;
      if (ld_ir)       ir_q       <= im_rdata;
      if (clr_halt) begin
        halted_q <= 1'b0;
      end else if (ld_ir && im_rdata[OPC_LSB +: FIELD_W] == OP_HLT) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign halted = halted_q;
  assign opcode = ir_q[OPC_LSB +: FIELD_W];
  assign mm     = ir_q[MM_LSB  +: FIELD_W];
  assign rd     = ir_q[RD_LSB  +: FIELD_W];
  assign rs     = ir_q[RS_LSB  +: FIELD_W];
  assign rt     = ir_q[RT_LSB  +: FIELD_W];
  assign imm    = ir_q[IMM_LSB +: IMM_W];

endmodule
